// File: rtl/rdma_pkg.sv
// rtl/rdma_pkg.sv - shared RDMA header layout, state encoding and checksum helpers
package rdma_pkg;

  localparam int HDR_BYTES  = 8;
  localparam int LANE_SRC   = 0;
  localparam int LANE_DST   = 2;
  localparam int LANE_LEN   = 4;
  localparam int LANE_CKSUM = 6;

  typedef enum logic [1:0] {
    ST_HEAD = 2'd0,
    ST_DATA = 2'd1,
    ST_DROP = 2'd2
  } rdma_state_e;

  function automatic logic [7:0] keep_from_rem(input logic [15:0] rem);
    logic [8:0] t;
    if (rem >= 16'(HDR_BYTES)) return 8'hFF;
    t = (9'd1 << rem[3:0]) - 9'd1;
    return t[7:0];
  endfunction

  // One's-complement add: the carry out of bit 15 wraps back into bit 0.
  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  // Fields are big-endian across two consecutive lanes.
  function automatic logic [15:0] hdr_field(input logic [63:0] d, input int lane);
    return {d[8*lane +: 8], d[8*(lane+1) +: 8]};
  endfunction

endpackage

// File: rtl/rdma_unpacker_if.sv
// rtl/rdma_unpacker_if.sv - 64-bit byte-keep stream with valid/ready/last handshake
interface rdma_unpacker_if;
  logic [63:0] data;
  logic [7:0]  keep;
  logic        valid;
  logic        last;
  logic        ready;

  modport master (output data, output keep, output valid, output last, input ready);
  modport slave  (input data, input keep, input valid, input last, output ready);
endinterface

// File: rtl/rdma_csum16.sv
// rtl/rdma_csum16.sv - 16-bit end-around-carry accumulator over keep-enabled byte lanes
module rdma_csum16
  import rdma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accum,
  input  logic [63:0] data,
  input  logic [7:0]  keep,
  output logic [15:0] sum_next,
  output logic [15:0] result
);

  // Lane 2i is the high byte of word i; a disabled lane contributes zero.
  always_comb begin
    sum_next = result;
    for (int i = 0; i < 4; i++) begin
      sum_next = ones_add(sum_next, {data[16*i +: 8] & {8{keep[2*i]}},
                                     data[16*i+8 +: 8] & {8{keep[2*i+1]}}});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
    end else if (clear) begin
      result <= '0;
    end else if (accum) begin
      result <= sum_next;
    end
  end

endmodule

// File: rtl/rdma_unpacker.sv
// rtl/rdma_unpacker.sv - strips the 8-byte RDMA header, trims payload keep to length,
// verifies length and checksum, and reports per-packet status and counters.
module rdma_unpacker
  import rdma_pkg::*;
#(
  parameter int CHECK_EN = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  rdma_unpacker_if.slave   slave,
  rdma_unpacker_if.master  master,
  output logic [15:0]      hdr_src_port,
  output logic [15:0]      hdr_dst_address,
  output logic [15:0]      hdr_length,
  output logic [15:0]      hdr_checksum,
  output logic             hdr_valid,
  output logic             stat_valid,
  output logic             stat_len_err,
  output logic             stat_cksum_err,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_count
);

  rdma_state_e state, state_nxt;
  logic [15:0] rem;
  logic        rem_le8;
  logic [15:0] in_len, in_ck;
  logic        ready_s, hdr_load, out_load, end_pkt, end_len_err;
  logic        csum_clear, csum_accum, out_last;
  logic [7:0]  out_keep;
  logic [15:0] end_sum, end_ck, csum_next, csum_result;
  logic [63:0] out_data_q;
  logic [7:0]  out_keep_q;
  logic        out_valid_q, out_last_q;

  assign in_len  = hdr_field(slave.data, LANE_LEN);
  assign in_ck   = hdr_field(slave.data, LANE_CKSUM);
  assign rem_le8 = (rem <= 16'd8);

  assign slave.ready  = ready_s;
  assign master.data  = out_data_q;
  assign master.keep  = out_keep_q;
  assign master.valid = out_valid_q;
  assign master.last  = out_last_q;

  rdma_csum16 u_csum (
    .clk      (clk),
    .rst      (rst),
    .clear    (csum_clear),
    .accum    (csum_accum),
    .data     (slave.data),
    .keep     (out_keep),
    .sum_next (csum_next),
    .result   (csum_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_HEAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ready_s     = 1'b0;
    hdr_load    = 1'b0;
    out_load    = 1'b0;
    end_pkt     = 1'b0;
    end_len_err = 1'b0;
    end_sum     = '0;
    end_ck      = hdr_checksum;
    csum_clear  = 1'b0;
    csum_accum  = 1'b0;
    out_keep    = keep_from_rem(rem);
    out_last    = 1'b0;
    case (state)
      ST_HEAD: begin
        ready_s = ~out_valid_q | master.ready;
        if (slave.valid && ready_s) begin
          hdr_load   = 1'b1;
          csum_clear = 1'b1;
          // Header-only packet: zero payload bytes, so the sum is just the field.
          if (slave.last) begin
            end_pkt     = 1'b1;
            end_len_err = (in_len != 16'd0);
            end_ck      = in_ck;
          end else if (in_len == 16'd0) begin
            state_nxt = ST_DROP;
          end else begin
            state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        ready_s = ~out_valid_q | master.ready;
        if (slave.valid && ready_s) begin
          out_load   = 1'b1;
          csum_accum = 1'b1;
          out_last   = rem_le8 | slave.last;
          if (slave.last) begin
            end_pkt     = 1'b1;
            end_len_err = ~rem_le8;
            end_sum     = csum_next;
            state_nxt   = ST_HEAD;
          end else if (rem_le8) begin
            state_nxt = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        ready_s = 1'b1;
        if (slave.valid && slave.last) begin
          end_pkt     = 1'b1;
          end_len_err = 1'b1;
          end_sum     = csum_result;
          state_nxt   = ST_HEAD;
        end
      end
      default: state_nxt = ST_HEAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem             <= '0;
      hdr_src_port    <= '0;
      hdr_dst_address <= '0;
      hdr_length      <= '0;
      hdr_checksum    <= '0;
      hdr_valid       <= 1'b0;
    end else begin
      hdr_valid <= hdr_load;
      if (hdr_load) begin
        rem             <= in_len;
        hdr_src_port    <= hdr_field(slave.data, LANE_SRC);
        hdr_dst_address <= hdr_field(slave.data, LANE_DST);
        hdr_length      <= in_len;
        hdr_checksum    <= in_ck;
      end else if (out_load) begin
        rem <= rem_le8 ? 16'd0 : rem - 16'd8;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (out_load) begin
      out_data_q  <= slave.data;
      out_keep_q  <= out_keep;
      out_last_q  <= out_last;
      out_valid_q <= 1'b1;
    end else if (master.ready) begin
      out_valid_q <= 1'b0;
    end
  end

  logic end_ck_err;
  assign end_ck_err = (CHECK_EN != 0) && (ones_add(end_sum, end_ck) != 16'hFFFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_valid     <= 1'b0;
      stat_len_err   <= 1'b0;
      stat_cksum_err <= 1'b0;
      pkt_count      <= '0;
      err_count      <= '0;
    end else begin
      stat_valid     <= end_pkt;
      stat_len_err   <= end_pkt & end_len_err;
      stat_cksum_err <= end_pkt & end_ck_err;
      if (end_pkt) begin
        pkt_count <= pkt_count + 1'b1;
        if ((end_len_err || end_ck_err) && (err_count != '1)) begin
          err_count <= err_count + 1'b1;
        end
      end
    end
  end

endmodule
